pool_control: RTL
=================

Name: pool_control

Overview:
- Downstream neighbour of the 5x5 convolution controller.
- Consumes the full MAPSIZE x MAPSIZE signed 32-bit convolution result map once that stage's done flag is high.
- Walks the map in 2x2 non-overlapping windows, selects the window maximum, then applies ReLU, right-shift requantisation and saturation.
- Writes a (MAPSIZE/2) x (MAPSIZE/2) signed 8-bit feature map sized to feed the next convolution layer.

Parameters:
- MAPSIZE, 28, input map edge length; must be even and >= 4 (elaboration-time check, $error otherwise).
- SHIFT, 8, arithmetic right-shift applied after ReLU (requantisation scale), range 0..31.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level/pulse; sampled in IDLE and DONE to begin a pass.
- inputs  input  signed [31:0] x [MAPSIZE-1:0][MAPSIZE-1:0]  convolution results; must stay stable for the whole pass.
- outputs  output  signed [7:0] x [MAPSIZE/2-1:0][MAPSIZE/2-1:0]  pooled, requantised map (registered).
- all_done  output  1  high exactly while state == DONE.

Behaviour:
- Reset (rst_n low, async): state=IDLE, x/y counters=0, max_r=0, every outputs entry=0, all_done=0.
- Counters x_idx, y_idx: width $clog2(MAPSIZE/2), range 0..MAPSIZE/2-1. Window (y,x) covers inputs rows 2y..2y+1, columns 2x..2x+1.
- FSM states: IDLE, POOL, WRITE, DONE.
  - IDLE: counters held at 0; start=1 -> POOL, otherwise stay.
  - POOL: max_r <= signed max of the 4 window elements. Ties are irrelevant (same value). -> WRITE.
  - WRITE:
    - outputs[y_idx][x_idx] <= requant(max_r).
    - If x_idx != MAPSIZE/2-1: x_idx+1.
    - Else if y_idx != MAPSIZE/2-1: x_idx=0, y_idx+1.
    - On the last window (both at limit): counters hold and next state is DONE; otherwise POOL.
  - DONE: all_done=1. start=1 -> counters cleared, next state POOL (restart). Otherwise stay.
- requant(v):
  - r = (v < 0) ? 0 : v (ReLU).
  - s = r >>> SHIFT.
  - out = (s > 127) ? 127 : s[7:0].
  - Result is never negative.
- Throughput: 2 cycles per output element.
- Latency: start sampled at edge 0 -> all_done visible after edge 2*(MAPSIZE/2)^2 (392 for MAPSIZE=28).
- Output entries not yet written in a pass keep their previous-pass values. Entries are written in raster order only.
- start while in POOL or WRITE: ignored.
- rst_n asserted mid-pass: immediate return to IDLE with all outputs cleared. No partial-pass state survives.
- Inputs changing mid-pass: undefined result, not checked.

Optional Feature:
- Macro: POOL_AVG_EN.
- Defined: POOL computes 34-bit signed sum of the 4 elements, then arithmetic >>> 2 (floor average), stored to max_r truncated to 32 bits; remaining pipeline unchanged. This is LeNet-style subsampling.
- Undefined: max pooling as above.
- Timing and handshake are identical in both builds.

Decomposition:
- Package pool_pkg:
  - pool_state_t enum {IDLE, POOL, WRITE, DONE}.
  - localparam OUT_MAX = 127.
  - function requant(input signed [31:0] v, input int shift) returning signed [7:0].
- One combinational sub-module, pool_window:
  - 4 x signed [31:0] in, signed [31:0] out.
  - Max or average, selected by POOL_AVG_EN.
- pool_control owns the FSM, counters, max_r and the output array.

Test Plan:
- MAPSIZE=4, SHIFT=0; inputs row-major 0..15; start pulse -> all_done after 8 cycles; outputs = {{5,7},{13,15}}.
- All inputs = -1000 -> every output 0 (ReLU).
- Window {70000, 1, 2, 3}, SHIFT=8 -> 70000>>>8 = 273 -> saturates to 127. Window {25600, 0, 0, 0} -> 100.
- Reset asserted after 3 cycles of a MAPSIZE=28 pass -> state IDLE, all_done=0, all outputs 0. New start -> completes in 392 cycles.
- In DONE, change inputs and pulse start -> second pass overwrites outputs[0][0] within 2 cycles; all_done drops the cycle after start and returns after 392 cycles.
- POOL_AVG_EN build, window {4, 5, 6, -3}, SHIFT=0 -> sum 12 >>> 2 = 3. Window {-8, -8, -8, -7} -> -31>>>2 = -8 -> ReLU 0.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg: shared FSM states and requantisation helper for the pooling stage
package pool_pkg;
  typedef enum logic [1:0] {IDLE, POOL, WRITE, DONE} pool_state_t;
  localparam int OUT_MAX = 127;
  function automatic logic signed [7:0] requant(input logic signed [31:0] v, input int shift);
    logic signed [31:0] s;
    s = (v < 0) ? 32'sd0 : v >>> shift;
    return (s > OUT_MAX) ? 8'sd127 : $signed(s[7:0]);
  endfunction
endpackage

// File: rtl/pool_control_if.sv
// pool_control_if: start/done handshake plus input and pooled map arrays
interface pool_control_if #(parameter int MAPSIZE = 28);
  logic start;
  logic signed [31:0] inputs [MAPSIZE-1:0][MAPSIZE-1:0];
  logic signed [7:0] outputs [MAPSIZE/2-1:0][MAPSIZE/2-1:0];
  logic all_done;
  modport master (output start, inputs, input outputs, all_done);
  modport slave (input start, inputs, output outputs, all_done);
endinterface

// File: rtl/pool_window.sv
// pool_window: reduces one 2x2 window to its max, or floor average when POOL_AVG_EN is defined
module pool_window (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic signed [31:0] c,
  input  logic signed [31:0] d,
  output logic signed [31:0] y
);
`ifdef POOL_AVG_EN
  logic signed [33:0] sum;
  assign sum = 34'(a) + 34'(b) + 34'(c) + 34'(d);
  assign y = 32'(sum >>> 2);
`else
  logic signed [31:0] m_ab, m_cd;
  assign m_ab = (a > b) ? a : b;
  assign m_cd = (c > d) ? c : d;
  assign y = (m_ab > m_cd) ? m_ab : m_cd;
`endif
endmodule

// File: rtl/pool_control.sv
// pool_control: 2x2 pooling + ReLU/shift/saturate over a conv map; POOL_AVG_EN selects average pooling
module pool_control
  import pool_pkg::*;
#(
  parameter int MAPSIZE = 28,
  parameter int SHIFT = 8
) (
  input logic clk,
  input logic rst_n,
  pool_control_if.slave bus
);
  localparam int H = MAPSIZE / 2;
  localparam int W = $clog2(H);
  if (MAPSIZE % 2 != 0 || MAPSIZE < 4 || SHIFT < 0 || SHIFT > 31) begin : g_bad_cfg
    $error("pool_control: MAPSIZE must be even and >= 4, SHIFT in 0..31");
  end
  pool_state_t state, next;
  logic [W-1:0] x_idx, y_idx;
  logic signed [31:0] max_r, win;
  logic last_x, last_y;
  assign last_x = x_idx == W'(H - 1);
  assign last_y = y_idx == W'(H - 1);
  assign bus.all_done = state == DONE;
  pool_window u_win (
    .a(bus.inputs[{y_idx, 1'b0}][{x_idx, 1'b0}]),
    .b(bus.inputs[{y_idx, 1'b0}][{x_idx, 1'b1}]),
    .c(bus.inputs[{y_idx, 1'b1}][{x_idx, 1'b0}]),
    .d(bus.inputs[{y_idx, 1'b1}][{x_idx, 1'b1}]),
    .y(win)
  );
  always_comb begin
    next = (state == IDLE)  ? (bus.start ? POOL : IDLE) :
           (state == POOL)  ? WRITE :
           (state == WRITE) ? ((last_x && last_y) ? DONE : POOL) :
                              (bus.start ? POOL : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_idx <= '0;
      y_idx <= '0;
      max_r <= '0;
      for (int i = 0; i < H; i++)
        for (int j = 0; j < H; j++)
          bus.outputs[i][j] <= '0;
    end else begin
      if (state == POOL) max_r <= win;
      // counters hold on the last window so DONE still points at it
      if (state == WRITE) begin
        bus.outputs[y_idx][x_idx] <= requant(max_r, SHIFT);
        if (!last_x) x_idx <= x_idx + 1'b1;
        else if (!last_y) begin
          x_idx <= '0;
          y_idx <= y_idx + 1'b1;
        end
      end
      if (state == IDLE || (state == DONE && bus.start)) begin
        x_idx <= '0;
        y_idx <= '0;
      end
    end
endmodule
